// File: rtl/hs_rr_arbiter.sv
// Round-robin arbiter sharing one 4-phase send/ack peripheral channel among NUM_REQ requesters.
// A watchdog aborts stalled peripheral requests and raises a sticky error flag.
module hs_rr_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 2,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [NUM_REQ-1:0]              req_send,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]              req_ack,
    output logic                            per_send,
    output logic [DATA_WIDTH-1:0]           per_data,
    input  logic                            per_ack,
    output logic [$clog2(NUM_REQ)-1:0]      grant_id,
    output logic                            busy,
    output logic                            timeout_err
);

    localparam int unsigned IDW = $clog2(NUM_REQ);
    localparam int unsigned CW  = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        RELEASE  = 2'd2,
        COMPLETE = 2'd3
    } state_t;

    state_t                state;
    logic [IDW-1:0]        rr_ptr;
    logic [CW-1:0]         count;

    logic                  found_hi;
    logic                  found_lo;
    logic [IDW-1:0]        sel_hi;
    logic [IDW-1:0]        sel_lo;
    logic [IDW-1:0]        sel_id;
    logic [DATA_WIDTH-1:0] data_hi;
    logic [DATA_WIDTH-1:0] data_lo;
    logic [DATA_WIDTH-1:0] sel_data;

    // Rotating priority: lowest requester at or above rr_ptr wins, else lowest overall (wrap).
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        sel_hi   = '0;
        sel_lo   = '0;
        data_hi  = '0;
        data_lo  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (req_send[i] && !found_hi && (IDW'(i) >= rr_ptr)) begin
                found_hi = 1'b1;
                sel_hi   = IDW'(i);
                data_hi  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
            if (req_send[i] && !found_lo) begin
                found_lo = 1'b1;
                sel_lo   = IDW'(i);
                data_lo  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        sel_id   = found_hi ? sel_hi  : sel_lo;
        sel_data = found_hi ? data_hi : data_lo;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            count       <= '0;
            req_ack     <= '0;
            per_send    <= 1'b0;
            per_data    <= '0;
            grant_id    <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req_send) begin
                        grant_id <= sel_id;
                        per_data <= sel_data;
                        per_send <= 1'b1;
                        busy     <= 1'b1;
                        count    <= '0;
                        state    <= REQ;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                REQ: begin
                    if (per_ack) begin
                        per_send <= 1'b0;
                        state    <= RELEASE;
                    end else if (count == CW'(TIMEOUT - 1)) begin
                        // Abort still completes the requester side; the error flag reports it.
                        per_send    <= 1'b0;
                        timeout_err <= 1'b1;
                        state       <= RELEASE;
                    end else begin
                        count <= count + CW'(1);
                    end
                end
                RELEASE: begin
                    if (!per_ack) begin
                        req_ack <= NUM_REQ'(1) << grant_id;
                        state   <= COMPLETE;
                    end
                end
                COMPLETE: begin
                    if (!req_send[grant_id]) begin
                        req_ack <= '0;
                        busy    <= 1'b0;
                        rr_ptr  <= (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + IDW'(1);
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
